// File: rtl/fifo_ag_pkg.sv
// Shared constants and helpers for the fifo_ag first-word-fall-through FIFO.
package fifo_ag_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    function automatic int ptrWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ag_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_ag_mem
    import fifo_ag_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       writeEn,
    input  logic [ptrWidth(DEPTH)-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0]      writeData,
    input  logic [ptrWidth(DEPTH)-1:0] readAddr,
    output logic [DATA_WIDTH-1:0]      readData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/fifo_ag.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Define FIFO_AG_LEVEL_EN to expose the occupancy count on the `level` port.
module fifo_ag
    import fifo_ag_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataInValid,
    output logic                  dataInReady,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataOutValid,
    input  logic                  dataOutReady
`ifdef FIFO_AG_LEVEL_EN
    ,
    output logic [ptrWidth(FIFO_DEPTH):0] level
`endif
);

    localparam int PW = ptrWidth(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] readPtr;
    logic [PW-1:0] writePtr;
    logic [CW-1:0] count;
    logic          writeFire;
    logic          readFire;

    // Ready depends only on count, so a full FIFO refuses a write even when
    // a read fires in the same cycle.
    assign dataInReady  = (count != CW'(FIFO_DEPTH));
    assign dataOutValid = (count != '0);
    assign writeFire    = dataInValid && dataInReady;
    assign readFire     = dataOutValid && dataOutReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            readPtr  <= '0;
            writePtr <= '0;
            count    <= '0;
        end else begin
            if (writeFire) begin
                writePtr <= writePtr + PW'(1);
            end
            if (readFire) begin
                readPtr <= readPtr + PW'(1);
            end
            if (writeFire && !readFire) begin
                count <= count + CW'(1);
            end else if (readFire && !writeFire) begin
                count <= count - CW'(1);
            end
        end
    end

    fifo_ag_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) uMem (
        .clk       (clk),
        .writeEn   (writeFire && !reset),
        .writeAddr (writePtr),
        .writeData (dataIn),
        .readAddr  (readPtr),
        .readData  (dataOut)
    );

`ifdef FIFO_AG_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_fifo_ag.sv
// Scoreboard-based bench for fifo_ag (DATA_WIDTH=32, FIFO_DEPTH=8).
module tb_fifo_ag;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] dataIn = '0;
    logic          dataInValid = 1'b0;
    logic          dataInReady;
    logic [DW-1:0] dataOut;
    logic          dataOutValid;
    logic          dataOutReady = 1'b0;
`ifdef FIFO_AG_LEVEL_EN
    logic [3:0]    level;
`endif

    fifo_ag #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .dataIn       (dataIn),
        .dataInValid  (dataInValid),
        .dataInReady  (dataInReady),
        .dataOut      (dataOut),
        .dataOutValid (dataOutValid),
        .dataOutReady (dataOutReady)
`ifdef FIFO_AG_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] expQ[$];
    int            mCount = 0;

    logic          obsReady, obsValid;
    logic [DW-1:0] obsData;
    logic [3:0]    obsLevel;
    logic          expReady, expValid;
    int            expLevel;
    logic          popped;
    logic [DW-1:0] expHead;

    // One clock cycle: drive inputs, sample outputs, update the reference model.
    task automatic tick(input logic rst, input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(negedge clk);
        reset = rst;
        dataInValid = iv;
        dataIn = d;
        dataOutReady = ordy;
        #1;
        obsReady = dataInReady;
        obsValid = dataOutValid;
        obsData  = dataOut;
`ifdef FIFO_AG_LEVEL_EN
        obsLevel = level;
`else
        obsLevel = 4'(mCount);
`endif
        expReady = (mCount != DEPTH);
        expValid = (mCount != 0);
        expLevel = mCount;
        popped   = 1'b0;
        if (rst) begin
            expQ.delete();
            mCount = 0;
        end else begin
            if (ordy && expValid) begin
                expHead = expQ.pop_front();
                popped = 1'b1;
            end
            if (iv && expReady) expQ.push_back(d);
            mCount = expQ.size();
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (obsValid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cycle %0d: got %b expected 0", i, obsValid);
            end
            checks++;
            if (obsReady !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready cycle %0d: got %b expected 1", i, obsReady);
            end
`ifdef FIFO_AG_LEVEL_EN
            checks++;
            if (obsLevel !== 4'd0) begin
                failures++;
                $display("FAIL reset_level cycle %0d: got %0d expected 0", i, obsLevel);
            end
`endif
        end
    endtask

    task automatic test_single();
        tick(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obsValid !== 1'b1 || !popped) begin
            failures++;
            $display("FAIL single_valid: got %b expected 1", obsValid);
        end
        checks++;
        if (obsData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_data: got %h expected deadbeef", obsData);
        end
        tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (obsValid !== 1'b0) begin
            failures++;
            $display("FAIL single_empty: got %b expected 0", obsValid);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b0, 1'b1, DW'(i), 1'b0);
            checks++;
            if (obsReady !== expReady) begin
                failures++;
                $display("FAIL fill_ready word %0d: got %b expected %b", i, obsReady, expReady);
            end
        end
        // Ninth word offered while full must be refused.
        tick(1'b0, 1'b1, DW'(9), 1'b0);
        checks++;
        if (obsReady !== 1'b0) begin
            failures++;
            $display("FAIL fill_full_ready: got %b expected 0", obsReady);
        end
`ifdef FIFO_AG_LEVEL_EN
        checks++;
        if (obsLevel !== 4'(expLevel)) begin
            failures++;
            $display("FAIL fill_level: got %0d expected %0d", obsLevel, expLevel);
        end
`endif
    endtask

    task automatic test_full_rw();
        tick(1'b0, 1'b1, DW'(9), 1'b1);
        checks++;
        if (obsReady !== 1'b0 || obsData !== expHead || !popped) begin
            failures++;
            $display("FAIL full_rw_fire: ready %b data %0d expected ready 0 data %0d", obsReady, obsData, expHead);
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obsReady !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_ready_after: got %b expected 1", obsReady);
        end
        checks++;
        if (obsData !== expHead || expHead !== DW'(2)) begin
            failures++;
            $display("FAIL drain_word2: got %0d expected %0d", obsData, expHead);
        end
        for (int i = 3; i <= DEPTH; i++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (obsValid !== 1'b1 || obsData !== DW'(i)) begin
                failures++;
                $display("FAIL drain_word%0d: valid %b data %0d expected %0d", i, obsValid, obsData, i);
            end
        end
        tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (obsValid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: got %b expected 0", obsValid);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, (i < 10), $urandom(), 1'b1);
            checks++;
            if (obsValid !== expValid || obsReady !== 1'b1) begin
                failures++;
                $display("FAIL stream_flags %0d: valid %b ready %b expected valid %b ready 1", i, obsValid, obsReady, expValid);
            end
            if (popped) begin
                checks++;
                if (obsData !== expHead) begin
                    failures++;
                    $display("FAIL stream_data %0d: got %h expected %h", i, obsData, expHead);
                end
            end
`ifdef FIFO_AG_LEVEL_EN
            checks++;
            if (obsLevel > 4'd1 || obsLevel !== 4'(expLevel)) begin
                failures++;
                $display("FAIL stream_level %0d: got %0d expected %0d", i, obsLevel, expLevel);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 32'h1000 + DW'(i), 1'b0);
        tick(1'b1, 1'b1, 32'hBAD0BAD0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (obsValid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_valid: got %b expected 0", obsValid);
        end
`ifdef FIFO_AG_LEVEL_EN
        checks++;
        if (obsLevel !== 4'd0) begin
            failures++;
            $display("FAIL midreset_level: got %0d expected 0", obsLevel);
        end
`endif
        tick(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obsValid !== 1'b1 || obsData !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL midreset_newword: valid %b data %h expected 1 a5a5a5a5", obsValid, obsData);
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obsValid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_old: valid %b data %h expected empty", obsValid, obsData);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_rw();
        test_stream();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
